// File: rtl/booth_r4_seq_mul.sv
// Iterative radix-4 Booth multiplier: one Booth digit retired per clock,
// start/busy/done handshake, signed or unsigned operands.
module booth_r4_seq_mul #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NDIG  = WIDTH / 2 + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned ACCW = 2 * WIDTH + 4;
  localparam int unsigned MW   = WIDTH + 3;
  localparam int unsigned CW   = $clog2(NDIG + 1);

  generate
    if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("booth_r4_seq_mul: WIDTH must be even and >= 4");
    end
    if (NDIG != WIDTH / 2 + 1) begin : g_bad_ndig
      $error("booth_r4_seq_mul: NDIG is derived and must not be overridden");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ACCW-1:0]      acc_q, acc_d;
  logic [ACCW-1:0]      mcand_q, mcand_d;
  logic [MW-1:0]        mplr_q, mplr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic                 a_sx_c, b_sx_c;
  logic [ACCW-1:0]      a_ext_c;
  logic [MW-1:0]        b_ext_c;
  logic [2:0]           trip_c;
  logic                 neg_c, two_c, one_c;
  logic [ACCW-1:0]      mag_c, pp_c, acc_sum_c;
  logic                 last_c;

  // Operand extension: b carries the implicit zero below its LSB.
  always_comb begin
    a_sx_c  = signed_mode & a[WIDTH-1];
    b_sx_c  = signed_mode & b[WIDTH-1];
    a_ext_c = {{(ACCW - WIDTH){a_sx_c}}, a};
    b_ext_c = {b_sx_c, b_sx_c, b, 1'b0};
  end

  // Booth digit decode; multiplicand is pre-shifted so no variable shifter is needed.
  always_comb begin
    trip_c    = mplr_q[2:0];
    neg_c     = trip_c[2];
    two_c     = (trip_c == 3'b011) || (trip_c == 3'b100);
    one_c     = trip_c[1] ^ trip_c[0];
    mag_c     = '0;
    if (two_c) begin
      mag_c = mcand_q << 1;
    end else if (one_c) begin
      mag_c = mcand_q;
    end
    pp_c      = neg_c ? ~mag_c : mag_c;
    acc_sum_c = acc_q + pp_c + ACCW'(neg_c);
    last_c    = (cnt_q == CW'(NDIG - 1));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    product_d = product_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          cnt_d   = '0;
          acc_d   = '0;
          mcand_d = a_ext_c;
          mplr_d  = b_ext_c;
        end
      end
      S_RUN: begin
        acc_d   = acc_sum_c;
        mcand_d = mcand_q << 2;
        mplr_d  = mplr_q >> 2;
        cnt_d   = cnt_q + CW'(1);
        if (last_c) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          product_d = acc_sum_c[2*WIDTH-1:0];
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// Directed bench for booth_r4_seq_mul at WIDTH=8, plus reference-multiply
// checks at WIDTH=16 and WIDTH=32.
module tb_booth_r4_seq_mul;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start8, sm8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] prod8;

  logic        start16, start32, smw;
  logic [31:0] aw, bw;
  logic        busy16, done16, busy32, done32;
  logic [31:0] prod16;
  logic [63:0] prod32;

  int n_vec = 0;
  int n_err = 0;

  booth_r4_seq_mul #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(prod8)
  );

  booth_r4_seq_mul #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(smw),
    .a(aw[15:0]), .b(bw[15:0]), .busy(busy16), .done(done16), .product(prod16)
  );

  booth_r4_seq_mul #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .signed_mode(smw),
    .a(aw), .b(bw), .busy(busy32), .done(done32), .product(prod32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after the accept edge; returns edges from accept to done.
  task automatic wait_done8(output int edges, output int bc);
    edges = 1;
    bc    = 0;
    while (done8 !== 1'b1 && edges < 40) begin
      if (busy8 === 1'b1) bc++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic op8(input string tag, input logic sm, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp);
    int e, bc;
    @(negedge clk);
    start8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0; sm8 = ~sm; a8 = ~a; b8 = ~b;
    wait_done8(e, bc);
    chk({tag, " product"}, 64'(prod8), 64'(exp));
    chk({tag, " latency"}, 64'(e), 64'd6);
    chk({tag, " busy cycles"}, 64'(bc), 64'd5);
    chk({tag, " busy at done"}, 64'(busy8), 64'd0);
    @(posedge clk); #1;
    chk({tag, " done width"}, 64'(done8), 64'd0);
    chk({tag, " product held"}, 64'(prod8), 64'(exp));
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m;
    m = (w == 16) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return m;
      3: return (m >> 1) + 32'd1;
      4: return m >> 1;
      default: return $urandom() & m;
    endcase
  endfunction

  task automatic opw(input int w, input logic sm, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] expv, obs;
    int e;
    if (w == 16) begin
      sa   = sm ? longint'($signed(a[15:0])) : longint'(a[15:0]);
      sb   = sm ? longint'($signed(b[15:0])) : longint'(b[15:0]);
      expv = 64'(sa * sb) & 64'h0000_0000_FFFF_FFFF;
    end else begin
      sa   = sm ? longint'($signed(a)) : longint'(a);
      sb   = sm ? longint'($signed(b)) : longint'(b);
      expv = 64'(sa * sb);
    end
    @(negedge clk);
    smw = sm; aw = a; bw = b;
    if (w == 16) start16 = 1'b1; else start32 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0; start32 = 1'b0; aw = ~a; bw = ~b; smw = ~sm;
    e = 1;
    while (((w == 16) ? done16 : done32) !== 1'b1 && e < 60) begin
      @(posedge clk); #1;
      e++;
    end
    obs = (w == 16) ? 64'(prod16) : prod32;
    chk($sformatf("w%0d s%0b %0h*%0h product", w, sm, a, b), obs, expv);
    chk($sformatf("w%0d latency", w), 64'(e), 64'(w / 2 + 2));
  endtask

  initial begin
    int e, bc, seen;
    rst = 1'b1; start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; start32 = 1'b0; smw = 1'b0; aw = '0; bw = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy8), 64'd0);
    chk("reset done", 64'(done8), 64'd0);
    chk("reset product", 64'(prod8), 64'd0);
    chk("reset product w32", prod32, 64'd0);
    @(negedge clk); rst = 1'b0;

    op8("s -128*-128", 1'b1, 8'h80, 8'h80, 16'h4000);
    op8("u ff*ff", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
    op8("s -1*-1", 1'b1, 8'hFF, 8'hFF, 16'h0001);
    op8("s 127*-128", 1'b1, 8'h7F, 8'h80, 16'hC080);
    op8("u 1*128", 1'b0, 8'h01, 8'h80, 16'h0080);

    // start held through RUN is ignored; start in DONE chains a second op.
    @(negedge clk);
    start8 = 1'b1; sm8 = 1'b0; a8 = 8'd6; b8 = 8'd7;
    @(posedge clk); #1;
    a8 = 8'd9; b8 = 8'd9;
    chk("b2b busy after accept", 64'(busy8), 64'd1);
    chk("b2b product held in run", 64'(prod8), 64'h0080);
    wait_done8(e, bc);
    chk("b2b first product", 64'(prod8), 64'h002A);
    chk("b2b first latency", 64'(e), 64'd6);
    a8 = 8'd3; b8 = 8'd5;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("b2b no idle busy", 64'(busy8), 64'd1);
    chk("b2b done dropped", 64'(done8), 64'd0);
    wait_done8(e, bc);
    chk("b2b second product", 64'(prod8), 64'h000F);
    chk("b2b second latency", 64'(e), 64'd6);

    // Abort after digit 2 has been retired.
    @(negedge clk);
    start8 = 1'b1; sm8 = 1'b1; a8 = 8'd10; b8 = 8'd10;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort busy", 64'(busy8), 64'd0);
    chk("abort done", 64'(done8), 64'd0);
    chk("abort product", 64'(prod8), 64'd0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) seen++;
    end
    chk("abort no done pulse", 64'(seen), 64'd0);
    op8("after abort -3*5", 1'b1, 8'hFD, 8'h05, 16'hFFF1);

    opw(16, 1'b1, 32'h8000, 32'h8000);
    opw(16, 1'b1, 32'h7FFF, 32'h8000);
    opw(16, 1'b0, 32'hFFFF, 32'hFFFF);
    opw(32, 1'b1, 32'h8000_0000, 32'h8000_0000);
    opw(32, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    opw(32, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 300; i++) opw(16, 1'($urandom_range(0, 1)), pick(16), pick(16));
    for (int i = 0; i < 300; i++) opw(32, 1'($urandom_range(0, 1)), pick(32), pick(32));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/booth_r4_seq_mul.md
Name: booth_r4_seq_mul

Overview:
- Parametrised, iterative radix-4 Booth multiplier.
- Successor to the single-triplet Booth digit encoder. The encoder is now internal and retires one Booth digit per clock.
- Adds a start/busy/done handshake and a signed/unsigned mode.
- Sits in the datapath as a multi-cycle multiply unit, area-optimised instead of an array multiplier.

Parameters:
- WIDTH, 16, operand width in bits. Must be even and ≥ 4; elaboration error otherwise.
- NDIG, WIDTH/2+1, number of Booth digits processed. Derived; must not be overridden.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled only when busy=0
- signed_mode  input  1  1: operands two's complement; 0: unsigned. Sampled with start.
- a  input  WIDTH  multiplicand, sampled with start
- b  input  WIDTH  multiplier, sampled with start
- busy  output  1  high while a multiply is in progress
- done  output  1  one-cycle pulse: product valid
- product  output  2*WIDTH  result, held until the next accepted start completes

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, product=0, accumulator and digit counter cleared. Reset takes priority over start and aborts any operation in flight.
- States:
  - IDLE: busy=0. start=1 → latch operands and mode, clear accumulator, counter=0 → RUN.
  - RUN: busy=1. Each edge retires digit i=counter, then counter++. After digit NDIG-1 → DONE.
  - DONE: busy=0, done=1 for exactly this cycle, product updated. Next edge → IDLE. If start=1 in DONE, it is accepted exactly as in IDLE and goes directly to RUN, allowing back-to-back operations.
- Operand extension:
  - b is extended to WIDTH+2 bits: sign-extended if signed_mode=1, zero-extended otherwise. An implicit 0 is appended below the LSB.
  - a is extended to WIDTH+2 bits the same way.
- Digit i uses triplet {bx[2i+1], bx[2i], bx[2i-1]}, with bx[-1]=0.
- Encoding is sign / 2x / 1x:
  - 000, 111 → 0
  - 001, 010 → +A
  - 011 → +2A
  - 100 → -2A
  - 101, 110 → -A
- Negation is two's complement: invert, then +1 carry-in.
- Accumulator is 2*WIDTH+4 bits, signed. acc += (digit·A_ext) << 2i, with the partial product sign-extended to full accumulator width.
- product = acc[2*WIDTH-1:0]. This is exact in both modes.
- Latency:
  - Accept at edge E0.
  - busy=1 during cycles E0..E(NDIG). busy is registered and rises after E0.
  - done=1 in the cycle following edge E(NDIG), i.e. NDIG+1 edges after acceptance.
  - For WIDTH=16: 9 busy cycles, then done.
- start while busy=1 is ignored; no queueing, no error flag.
- Operand and mode inputs may change freely after acceptance without affecting the result.
- product keeps its previous value during RUN. It changes only on the edge that enters DONE.
- done is never high while busy is high.

Test Plan:
- WIDTH=8, signed, a=-128 (0x80), b=-128 → product=0x4000, done exactly 6 edges after accept, busy high 5 cycles.
- WIDTH=8, unsigned, a=0xFF, b=0xFF → product=0xFE01. Same operands with signed_mode=1 (-1·-1) → product=0x0001.
- WIDTH=8, signed, a=0x7F, b=0x80 (127·-128) → 0xC080. Unsigned a=0x01, b=0x80 → 0x0080.
- start held high during RUN with different operands → ignored; original product delivered. start=1 in DONE cycle with a=3, b=5 → second op runs back-to-back, product=0x000F, no idle cycle.
- rst asserted mid-RUN (after digit 2) → next cycle busy=0, done=0, product=0. No done pulse for the aborted op; a following start completes correctly.
- Random regression, WIDTH=16 and WIDTH=32, 10k ops each, both modes, including 0, 1, all-ones, MIN and MAX operands → product matches a reference multiply, and latency is constant at NDIG+1.
